// File: rtl/key_pkg.sv
// Shared key types: FSM state encoding and default timing
// constants used by the key detector and the menu FSMs.
package key_pkg;

  typedef logic [1:0] key_state_t;

  localparam key_state_t ST_IDLE = 2'd0;
  localparam key_state_t ST_HELD = 2'd1;
  localparam key_state_t ST_LONG = 2'd2;

  localparam int unsigned KEY_N_DEF    = 5;
  localparam int unsigned KEY_CNT_W    = 32;
  localparam int unsigned KEY_DEB_DEF  = 2000000;
  localparam int unsigned KEY_LONG_DEF = 300000000;
  localparam int unsigned KEY_REP_DEF  = 50000000;

endpackage

// File: rtl/key_event_detector_if.sv
// Key bundle: raw levels in, debounced level and events out.
// master = detector side, slave = consumer/stimulus side.
interface key_event_detector_if #(
  parameter int N_KEYS = 5
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] pressed;
  logic [N_KEYS-1:0] short_pulse;
  logic [N_KEYS-1:0] long_pulse;
  logic [N_KEYS-1:0] long_hold;
  logic [N_KEYS-1:0] repeat_pulse;

  modport master (
    input  key_in,
    output pressed, short_pulse, long_pulse,
    output long_hold, repeat_pulse
  );

  modport slave (
    output key_in,
    input  pressed, short_pulse, long_pulse,
    input  long_hold, repeat_pulse
  );
endinterface

// File: rtl/key_channel.sv
// One key: 2-flop sync, debounce, IDLE/HELD/LONG press FSM.
// Ports: clk, rst_n (sync, active low), key_i raw level;
// pressed_o, short_o, long_o, hold_o, rep_o registered outputs.
// KEY_REPEAT_EN adds the auto-repeat counter; else rep_o = 0.
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned CNT_W             = KEY_CNT_W,
  parameter int unsigned DEBOUNCE_CYCLES   = KEY_DEB_DEF,
  parameter int unsigned LONG_PRESS_CYCLES = KEY_LONG_DEF,
  parameter int unsigned REPEAT_CYCLES     = KEY_REP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic pressed_o,
  output logic short_o,
  output logic long_o,
  output logic hold_o,
  output logic rep_o
);

  if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1 ||
      REPEAT_CYCLES < 1) begin : g_cfg_err
    $error("key_channel: timing parameters must be >= 1");
  end

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_C =
    CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       sync_q;
  logic             pressed_q, pressed_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  key_state_t       state_q, state_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             lhold_q, lhold_d;
  logic             differ, flip, rise, fall;

  // flip marks the edge on which the debounced level changes
  always_comb begin
    differ    = sync_q[1] ^ pressed_q;
    flip      = differ && (db_cnt_q == DB_LAST);
    db_cnt_d  = (differ && !flip) ? db_cnt_q + 1'b1 : '0;
    pressed_d = pressed_q ^ flip;
    rise      = flip & ~pressed_q;
    fall      = flip & pressed_q;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    lhold_d = lhold_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (rise) begin
          state_d = ST_HELD;
          hold_d  = CNT_W'(1);
        end
      end
      (state_q == ST_HELD): begin
        // reaching the threshold wins over a same-edge release
        if (hold_q == LONG_C) begin
          long_d = 1'b1;
          if (fall) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else begin
            state_d = ST_LONG;
            lhold_d = 1'b1;
          end
        end else if (fall) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
          hold_d  = '0;
        end else if (hold_q != CNT_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      (state_q == ST_LONG): begin
        if (fall) begin
          state_d = ST_IDLE;
          lhold_d = 1'b0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
        lhold_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      pressed_q <= 1'b0;
      db_cnt_q  <= '0;
      hold_q    <= '0;
      state_q   <= ST_IDLE;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      lhold_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_i};
      pressed_q <= pressed_d;
      db_cnt_q  <= db_cnt_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
      short_q   <= short_d;
      long_q    <= long_d;
      lhold_q   <= lhold_d;
    end
  end

  assign pressed_o = pressed_q;
  assign short_o   = short_q;
  assign long_o    = long_q;
  assign hold_o    = lhold_q;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST =
    CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_q, rep_d;

  always_comb begin
    rep_cnt_d = '0;
    rep_d     = 1'b0;
    if (state_q == ST_LONG && !fall) begin
      if (rep_cnt_q == REP_LAST) begin
        rep_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
      rep_q     <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_q     <= rep_d;
    end
  end

  assign rep_o = rep_q;
`else
  assign rep_o = 1'b0;
`endif

endmodule

// File: rtl/key_event_detector.sv
// N_KEYS independent debounced short/long press detectors.
// Ports: clk, rst_n (sync, active low), kif (master modport).
// Macro KEY_REPEAT_EN enables repeat_pulse auto-repeat.
module key_event_detector
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS            = KEY_N_DEF,
  parameter int unsigned CNT_W             = KEY_CNT_W,
  parameter int unsigned DEBOUNCE_CYCLES   = KEY_DEB_DEF,
  parameter int unsigned LONG_PRESS_CYCLES = KEY_LONG_DEF,
  parameter int unsigned REPEAT_CYCLES     = KEY_REP_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  key_event_detector_if.master kif
);

  logic [N_KEYS-1:0] pressed_w;
  logic [N_KEYS-1:0] short_w;
  logic [N_KEYS-1:0] long_w;
  logic [N_KEYS-1:0] hold_w;
  logic [N_KEYS-1:0] rep_w;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .CNT_W            (CNT_W),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_i    (kif.key_in[i]),
      .pressed_o(pressed_w[i]),
      .short_o  (short_w[i]),
      .long_o   (long_w[i]),
      .hold_o   (hold_w[i]),
      .rep_o    (rep_w[i])
    );
  end

  assign kif.pressed      = pressed_w;
  assign kif.short_pulse  = short_w;
  assign kif.long_pulse   = long_w;
  assign kif.long_hold    = hold_w;
  assign kif.repeat_pulse = rep_w;

endmodule

// File: tb/tb_key_event_detector.sv
// Scoreboard bench for key_event_detector: expected event
// cycles are queued at stimulus time and matched on output.
module tb_key_event_detector;

  localparam int NK = 5;
  localparam int DB = 4;
  localparam int LP = 20;
  localparam int RP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  key_event_detector_if #(.N_KEYS(NK)) kif();

  key_event_detector #(
    .N_KEYS           (NK),
    .CNT_W            (16),
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP),
    .REPEAT_CYCLES    (RP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kif  (kif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int ch;
    int kind;
    int cyc;
  } ev_t;

  ev_t   sb[$];
  string kn[7];

  task automatic check_eq(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d",
                  tag, got, exp);
  endtask

  task automatic push_ev(int ch, int kind, int c);
    ev_t e;
    e.ch   = ch;
    e.kind = kind;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // kinds: 0 rise 1 fall 2 short 3 long 4 rep 5 lh_on 6 lh_off
  task automatic push_press(int ch, int st, int hold);
    int rise;
    int fall;
    rise = st + 2 + DB;
    fall = rise + hold;
    push_ev(ch, 0, rise);
    push_ev(ch, 1, fall);
    if (hold < LP) begin
      push_ev(ch, 2, fall);
    end else begin
      push_ev(ch, 3, rise + LP);
      if (hold > LP) begin
        push_ev(ch, 5, rise + LP);
        push_ev(ch, 6, fall);
`ifdef KEY_REPEAT_EN
        for (int t = rise + LP + RP; t < fall; t += RP)
          push_ev(ch, 4, t);
`endif
      end
    end
  endtask

  task automatic match(int ch, int kind);
    int    idx;
    string tag;
    idx = -1;
    tag = $sformatf("ch%0d_%s", ch, kn[kind]);
    foreach (sb[i])
      if (idx < 0 && sb[i].ch == ch && sb[i].kind == kind)
        idx = i;
    if (idx >= 0) begin
      check_eq(tag, cyc, sb[idx].cyc);
      sb.delete(idx);
    end else begin
      check_eq({tag, "_unexpected"}, cyc, -1);
    end
  endtask

  logic [NK-1:0] pp;
  logic [NK-1:0] plh;
  bit            mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < NK; c++) begin
        if (kif.pressed[c] && !pp[c])     match(c, 0);
        if (!kif.pressed[c] && pp[c])     match(c, 1);
        if (kif.short_pulse[c])           match(c, 2);
        if (kif.long_pulse[c])            match(c, 3);
        if (kif.repeat_pulse[c])          match(c, 4);
        if (kif.long_hold[c] && !plh[c])  match(c, 5);
        if (!kif.long_hold[c] && plh[c])  match(c, 6);
      end
      pp  = kif.pressed;
      plh = kif.long_hold;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(string pfx);
    check_eq({pfx, "_pressed"}, int'(kif.pressed), 0);
    check_eq({pfx, "_short"}, int'(kif.short_pulse), 0);
    check_eq({pfx, "_long"}, int'(kif.long_pulse), 0);
    check_eq({pfx, "_lhold"}, int'(kif.long_hold), 0);
    check_eq({pfx, "_rep"}, int'(kif.repeat_pulse), 0);
  endtask

  initial begin
    int c;
    int r;
    kn = '{"rise", "fall", "short", "long",
           "rep", "lh_on", "lh_off"};
    kif.key_in = '0;
    rst_n = 1'b0;
    tick(3);
    check_zero("rst");
    pp  = kif.pressed;
    plh = kif.long_hold;
    mon_en = 1'b1;
    rst_n = 1'b1;
    tick(2);

    // short press
    c = cyc;
    kif.key_in[0] = 1'b1;
    push_press(0, c, 10);
    tick(10);
    kif.key_in[0] = 1'b0;
    tick(20);

    // long press, long enough for several repeats
    c = cyc;
    kif.key_in[1] = 1'b1;
    push_press(1, c, 60);
    tick(60);
    kif.key_in[1] = 1'b0;
    tick(30);

    // one cycle short of long
    c = cyc;
    kif.key_in[2] = 1'b1;
    push_press(2, c, LP - 1);
    tick(LP - 1);
    kif.key_in[2] = 1'b0;
    tick(30);

    // release on the very cycle long is reached
    c = cyc;
    kif.key_in[2] = 1'b1;
    push_press(2, c, LP);
    tick(LP);
    kif.key_in[2] = 1'b0;
    tick(30);

    // bounce shorter than the debounce window
    for (int k = 0; k < 5; k++) begin
      kif.key_in[2] = 1'b1;
      tick(3);
      kif.key_in[2] = 1'b0;
      tick(3);
    end
    tick(20);
    check_eq("bounce_pressed", int'(kif.pressed[2]), 0);

    // reset in the middle of a held press
    c = cyc;
    kif.key_in[3] = 1'b1;
    push_ev(3, 0, c + 2 + DB);
    tick(2 + DB + 15);
    rst_n = 1'b0;
    push_ev(3, 1, cyc + 1);
    tick(1);
    r = cyc;
    check_zero("midrst");
    rst_n = 1'b1;
    push_press(3, r, 30);
    tick(30);
    kif.key_in[3] = 1'b0;
    tick(30);

    // simultaneous presses on two channels
    c = cyc;
    kif.key_in[0] = 1'b1;
    kif.key_in[4] = 1'b1;
    push_press(0, c, 25);
    push_press(4, c, 25);
    tick(25);
    kif.key_in[0] = 1'b0;
    kif.key_in[4] = 1'b0;
    tick(30);

    check_eq("sb_left", sb.size(), 0);
    foreach (sb[i])
      $display("FAIL missing ch%0d_%s: got none, expected at %0d",
               sb[i].ch, kn[sb[i].kind], sb[i].cyc);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
